reorder_buffer: RTL

Parametrised reorder buffer for the out-of-order core. It allocates ROB tags to the rs scheduler, captures results from `NUM_CDB` common data buses and forwards operands to the issue unit, with same-cycle CDB bypass. It hands the head entry to the commit unit in program order and supports a single-cycle full flush on branch mispredict. It sits between the rs scheduler/issue unit (allocate, query), the CDB arbiter (writeback) and the commit unit (dequeue, flush).

---
 rtl/reorder_buffer_pkg.sv | 32 +++
 rtl/reorder_buffer_cdb_match.sv | 36 +++
 rtl/reorder_buffer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared ROB/CDB types, itype encodings and tag constants.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

    // Tag 0 means "no tag / value lives in the register file"
    localparam logic [ROB_TAG_W-1:0] ROB_TAG_NONE = '0;

    localparam logic [1:0] ITYPE_BRANCH = 2'b00;
    localparam logic [1:0] ITYPE_STORE  = 2'b01;
    localparam logic [1:0] ITYPE_LOAD   = 2'b10;
    localparam logic [1:0] ITYPE_REG    = 2'b11;

    typedef struct packed {
        logic [1:0]  itype;
        logic        ready;
        logic [31:0] value;
        logic        branch_result;
        logic [4:0]  dest_reg;
        logic [31:0] pc;
    } ROB_entry_t;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] dest_ROB_entry;
        logic [31:0]          result;
        logic                 branch_result;
        logic                 load_step1;
        logic                 from_commit;
    } CDB_packet_t;

endpackage

// File: rtl/reorder_buffer_cdb_match.sv
// rob_cdb_match: finds the qualifying CDB broadcast for one tag.
//   tag_i           tag to look for (0 never matches)
//   cdb_i           CDB packets, one per port
//   hit_o           a qualifying broadcast exists
//   result_o        result of the lowest-index matching port
//   branch_result_o branch_result of the lowest-index matching port
module rob_cdb_match
    import reorder_buffer_pkg::*;
#(
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 4
) (
    input  logic [TAG_W-1:0] tag_i,
    input  CDB_packet_t      cdb_i [NUM_CDB],
    output logic             hit_o,
    output logic [31:0]      result_o,
    output logic             branch_result_o
);

    // Scanning from the top port down lets the lowest index overwrite last.
    always_comb begin
        hit_o           = 1'b0;
        result_o        = '0;
        branch_result_o = 1'b0;
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (32'(tag_i) != 32'(ROB_TAG_NONE) &&
                32'(tag_i) == 32'(cdb_i[p].dest_ROB_entry) &&
                !cdb_i[p].load_step1 && !cdb_i[p].from_commit) begin
                hit_o           = 1'b1;
                result_o        = cdb_i[p].result;
                branch_result_o = cdb_i[p].branch_result;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit queue with CDB capture and operand forwarding.
//   alloc_*   tag allocation to the scheduler
//   cdb_in    result broadcasts captured into waiting slots
//   q_*       operand queries with same-cycle CDB bypass
//   head_*    head entry to the commit unit; commit_en dequeues it
//   flush     drops every entry in one cycle
//   count/full/empty occupancy
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_valid,
    input  ROB_entry_t       alloc_entry,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  CDB_packet_t      cdb_in [NUM_CDB],
    input  logic [TAG_W-1:0] q_tag [2],
    output logic [31:0]      q_data [2],
    output logic             q_ready [2],
    output ROB_entry_t       head,
    output logic [TAG_W-1:0] head_tag,
    output logic             head_valid,
    output logic             head_store,
    input  logic             commit_en,
    input  logic             flush,
    output logic [TAG_W-1:0] count,
    output logic             full,
    output logic             empty
);

    ROB_entry_t       ent_q [DEPTH];
    ROB_entry_t       ent_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [TAG_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, cnt_q, cnt_d;

    logic [DEPTH-1:0] hit;
    logic [DEPTH-1:0] hit_br;
    logic [31:0]      hit_res [DEPTH];
    logic [1:0]       q_hit, q_br_unused;
    logic [31:0]      q_res [2];

    logic do_alloc, do_commit;

    // Pointers skip slot 0, which is reserved for the "no tag" encoding.
    function automatic logic [TAG_W-1:0] nxt(input logic [TAG_W-1:0] p);
        return (p == TAG_W'(DEPTH - 1)) ? TAG_W'(1) : p + 1'b1;
    endfunction

    assign empty       = cnt_q == '0;
    assign full        = cnt_q == TAG_W'(DEPTH - 1);
    assign count       = cnt_q;
    assign alloc_ready = !full;
    assign alloc_tag   = alloc_ready ? wptr_q : '0;
    assign head        = ent_q[rptr_q];
    assign head_tag    = rptr_q;
    assign head_valid  = !empty && ent_q[rptr_q].ready;
    assign head_store  = !empty && ent_q[rptr_q].itype == ITYPE_STORE;
    assign do_alloc    = alloc_valid && alloc_ready && !flush;
    assign do_commit   = commit_en && head_valid && !flush;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        rob_cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W)) u_match (
            .tag_i          (TAG_W'(g)),
            .cdb_i          (cdb_in),
            .hit_o          (hit[g]),
            .result_o       (hit_res[g]),
            .branch_result_o(hit_br[g])
        );
    end

    for (genvar k = 0; k < 2; k++) begin : g_query
        logic ok, byp;
        rob_cdb_match #(.NUM_CDB(NUM_CDB), .TAG_W(TAG_W)) u_match (
            .tag_i          (q_tag[k]),
            .cdb_i          (cdb_in),
            .hit_o          (q_hit[k]),
            .result_o       (q_res[k]),
            .branch_result_o(q_br_unused[k])
        );
        assign ok         = q_tag[k] != '0 && vld_q[q_tag[k]];
        // Stores are never written by the CDB, so they never take the bypass either.
        assign byp        = q_hit[k] && ent_q[q_tag[k]].itype != ITYPE_STORE;
        assign q_ready[k] = ok && (byp || ent_q[q_tag[k]].ready);
        assign q_data[k]  = !ok ? '0 : byp ? q_res[k] : ent_q[q_tag[k]].value;
    end

    always_comb begin
        ent_d  = ent_q;
        vld_d  = vld_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (!flush && vld_q[i] && hit[i] && ent_q[i].itype != ITYPE_STORE) begin
                if (ent_q[i].itype == ITYPE_BRANCH) ent_d[i].branch_result = hit_br[i];
                if (ent_q[i].itype[1]) ent_d[i].value = hit_res[i];
                ent_d[i].ready = 1'b1;
            end
        end
        if (do_commit) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = nxt(rptr_q);
        end
        if (do_alloc) begin
            ent_d[wptr_q]       = alloc_entry;
            ent_d[wptr_q].ready = 1'b0;
            ent_d[wptr_q].value = '0;
            vld_d[wptr_q]       = 1'b1;
            wptr_d              = nxt(wptr_q);
        end
        cnt_d = cnt_q + TAG_W'(do_alloc) - TAG_W'(do_commit);
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent_d[i].ready = 1'b0;
            vld_d  = '0;
            wptr_d = TAG_W'(1);
            rptr_d = TAG_W'(1);
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q  <= '{default: '0};
            vld_q  <= '0;
            wptr_q <= TAG_W'(1);
            rptr_q <= TAG_W'(1);
            cnt_q  <= '0;
        end else begin
            ent_q  <= ent_d;
            vld_q  <= vld_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule
